// File: rtl/dekatron_seq_pkg.sv
// Shared definitions for the dekatron counter command sequencer:
// opcodes, FSM encoding, counter range and BCD digit limits.
package dekatron_seq_pkg;

    localparam logic [1:0] OP_LOAD      = 2'b00;
    localparam logic [1:0] OP_STEP_UP   = 2'b01;
    localparam logic [1:0] OP_STEP_DOWN = 2'b10;
    localparam logic [1:0] OP_SEEK      = 2'b11;

    localparam logic [7:0] CNT_MAX       = 8'd255;
    localparam logic [7:0] SEEK_HALF     = 8'd128;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [1:0] BCD_HUND_MAX  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK_ARG = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE_HI  = 3'd3,
        ST_PULSE_LO  = 3'd4,
        ST_VERIFY    = 3'd5,
        ST_FINISH    = 3'd6
    } seq_state_t;

    // One counter step with the same 8-bit wrap the dekatron chain has at its limits.
    function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic down);
        logic [7:0] nxt;
        if (down) begin
            nxt = pos - 8'd1;
        end else begin
            nxt = pos + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dekatron_counter_seq_if.sv
// Command channel of the dekatron sequencer: valid/ready handshake with opcode and BCD value.
interface dekatron_counter_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [9:0] cmd_value;

    modport master (output cmd_valid, output cmd_op, output cmd_value, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_value, output cmd_ready);
endinterface

// File: rtl/bcd3_to_bin.sv
// Combinational 3-digit BCD (8-4-2-1) to 8-bit binary converter with a
// validity flag covering bad digits and values beyond the counter range.
module bcd3_to_bin
    import dekatron_seq_pkg::*;
(
    input  logic [9:0] bcd,
    output logic [7:0] bin,
    output logic       valid
);
    logic [9:0] sum_s;
    logic       digits_ok_s;

    // Weighted digit sum; 10 bits hold the worst case of malformed digits.
    always_comb begin
        sum_s       = ({8'd0, bcd[9:8]} * 10'd100) + ({6'd0, bcd[7:4]} * 10'd10) + {6'd0, bcd[3:0]};
        digits_ok_s = (bcd[9:8] <= BCD_HUND_MAX) && (bcd[7:4] <= BCD_DIGIT_MAX) && (bcd[3:0] <= BCD_DIGIT_MAX);
        valid       = digits_ok_s && (sum_s <= {2'b00, CNT_MAX});
        bin         = sum_s[7:0];
    end
endmodule

// File: rtl/dekatron_counter_seq.sv
// Command sequencer for a 3-digit dekatron counter: issues timed Step pulses,
// holds Reverse, loads through Set/In and checks the read-back after every pulse.
module dekatron_counter_seq
    import dekatron_seq_pkg::*;
#(
    parameter int unsigned STEP_HI   = 2,
    parameter int unsigned STEP_LO   = 2,
    parameter int unsigned DIR_SETUP = 1
)(
    input  logic                  Clk,
    input  logic                  Rst_n,
    dekatron_counter_seq_if.slave cmd,
    input  logic [9:0]            CntOut,
    output logic                  Step,
    output logic                  Reverse,
    output logic                  Set,
    output logic [9:0]            In,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [7:0] SETUP_LD = 8'(DIR_SETUP - 1);
    localparam logic [7:0] HI_LD    = 8'(STEP_HI - 1);
    localparam logic [7:0] LO_LD    = 8'(STEP_LO - 1);

    seq_state_t state_r, state_s;
    logic [1:0] op_r, op_s;
    logic [9:0] value_r, value_s;
    logic [7:0] pos_r, pos_s;
    logic [7:0] count_r, count_s;
    logic [7:0] timer_r, timer_s;
    logic       dir_r, dir_s;
    logic       err_r, err_s;

    logic       cmd_ready_r, cmd_ready_s;
    logic       step_r, step_s;
    logic       reverse_r, reverse_s;
    logic       set_r, set_s;
    logic [9:0] in_r, in_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       active_s;

    logic [7:0] val_bin_s, cnt_bin_s, seek_d_s;
    logic       val_ok_s, cnt_ok_s;

    bcd3_to_bin u_val_conv (.bcd(value_r), .bin(val_bin_s), .valid(val_ok_s));
    bcd3_to_bin u_cnt_conv (.bcd(CntOut),  .bin(cnt_bin_s), .valid(cnt_ok_s));

    // Next-state, argument decode and expected-position tracking.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        value_s  = value_r;
        pos_s    = pos_r;
        count_s  = count_r;
        timer_s  = timer_r;
        dir_s    = dir_r;
        err_s    = err_r;
        seek_d_s = val_bin_s - cnt_bin_s;
        case (state_r)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_s    = cmd.cmd_op;
                    value_s = cmd.cmd_value;
                    err_s   = 1'b0;
                    state_s = ST_CHECK_ARG;
                end else begin
                    dir_s = 1'b0;
                end
            end
            ST_CHECK_ARG: begin
                pos_s = cnt_bin_s;
                case (op_r)
                    OP_LOAD: begin
                        dir_s   = 1'b0;
                        count_s = 8'd1;
                    end
                    OP_STEP_UP: begin
                        dir_s   = 1'b0;
                        count_s = val_bin_s;
                    end
                    OP_STEP_DOWN: begin
                        dir_s   = 1'b1;
                        count_s = val_bin_s;
                    end
                    OP_SEEK: begin
                        // Shorter way round the ring; an exact half turn goes up.
                        if (seek_d_s <= SEEK_HALF) begin
                            dir_s   = 1'b0;
                            count_s = seek_d_s;
                        end else begin
                            dir_s   = 1'b1;
                            count_s = 8'd0 - seek_d_s;
                        end
                    end
                    default: begin
                        dir_s   = 1'b0;
                        count_s = 8'd0;
                    end
                endcase
                if (!val_ok_s) begin
                    err_s   = 1'b1;
                    state_s = ST_FINISH;
                end else if (count_s == 8'd0) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_SETUP;
                    timer_s = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (timer_r == 8'd0) begin
                    state_s = ST_PULSE_HI;
                    timer_s = HI_LD;
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            ST_PULSE_HI: begin
                if (timer_r == 8'd0) begin
                    state_s = ST_PULSE_LO;
                    timer_s = LO_LD;
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            ST_PULSE_LO: begin
                if (timer_r == 8'd0) begin
                    state_s = ST_VERIFY;
                    if (op_r == OP_LOAD) begin
                        pos_s = val_bin_s;
                    end else begin
                        pos_s = step_pos(pos_r, dir_r);
                    end
                end else begin
                    timer_s = timer_r - 8'd1;
                end
            end
            ST_VERIFY: begin
                if (!cnt_ok_s || (cnt_bin_s != pos_r)) begin
                    err_s   = 1'b1;
                    state_s = ST_FINISH;
                end else begin
                    count_s = count_r - 8'd1;
                    if (count_s == 8'd0) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_PULSE_HI;
                        timer_s = HI_LD;
                    end
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state being entered, so each one comes straight off a flop.
    always_comb begin
        active_s    = (state_s == ST_SETUP) || (state_s == ST_PULSE_HI) ||
                      (state_s == ST_PULSE_LO) || (state_s == ST_VERIFY);
        cmd_ready_s = (state_s == ST_IDLE);
        busy_s      = active_s || (state_s == ST_CHECK_ARG);
        done_s      = (state_s == ST_FINISH);
        step_s      = (state_s == ST_PULSE_HI);
        reverse_s   = active_s && dir_s;
        set_s       = (op_s == OP_LOAD) && active_s && (state_s != ST_VERIFY);
        if (set_s) begin
            in_s = value_s;
        end else begin
            in_s = 10'd0;
        end
    end

    // State, command context and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            value_r     <= 10'd0;
            pos_r       <= 8'd0;
            count_r     <= 8'd0;
            timer_r     <= 8'd0;
            dir_r       <= 1'b0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            step_r      <= 1'b0;
            reverse_r   <= 1'b0;
            set_r       <= 1'b0;
            in_r        <= 10'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            value_r     <= value_s;
            pos_r       <= pos_s;
            count_r     <= count_s;
            timer_r     <= timer_s;
            dir_r       <= dir_s;
            err_r       <= err_s;
            cmd_ready_r <= cmd_ready_s;
            step_r      <= step_s;
            reverse_r   <= reverse_s;
            set_r       <= set_s;
            in_r        <= in_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign cmd.cmd_ready = cmd_ready_r;
    assign Step          = step_r;
    assign Reverse       = reverse_r;
    assign Set           = set_r;
    assign In            = in_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

endmodule

// File: tb/tb_dekatron_counter_seq.sv
// Scoreboard bench for dekatron_counter_seq with a behavioural counter standing in
// for the dekatron chain and a reference model computing each command's outcome.
module tb_dekatron_counter_seq;
    import dekatron_seq_pkg::*;

    localparam int H = 2;
    localparam int L = 2;
    localparam int D = 1;
    localparam int P = H + L + 1;

    typedef struct {
        string      name;
        int         pulses;
        int         err;
        int         final_pos;
        int         dir;
        int         busy_cyc;
        int         set_cyc;
        logic [9:0] value;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [9:0] CntOut;
    logic       Step, Reverse, Set, busy, done, err;
    logic [9:0] In;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   cnt = 0;
    int   total_pulses = 0;
    int   freeze_at = -1;

    dekatron_counter_seq_if cmd_if();

    dekatron_counter_seq #(.STEP_HI(H), .STEP_LO(L), .DIR_SETUP(D)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .cmd(cmd_if), .CntOut(CntOut),
        .Step(Step), .Reverse(Reverse), .Set(Set), .In(In),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [9:0] to_bcd(input int n);
        logic [9:0] r;
        r[9:8] = 2'(n / 100);
        r[7:4] = 4'((n / 10) % 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [9:0] b);
        int h, t, u;
        h = b[9:8];
        t = b[7:4];
        u = b[3:0];
        return h * 100 + t * 10 + u;
    endfunction

    // Outcome of one command from a counter at pos; freeze_k >= 0 means the counter stops after freeze_k pulses.
    function automatic exp_t model(input logic [1:0] op, input logic [9:0] v, input int pos, input int freeze_k);
        exp_t e;
        int h, t, u, val, n, d;
        h = v[9:8];
        t = v[7:4];
        u = v[3:0];
        val = h * 100 + t * 10 + u;
        e.value = v; e.dir = 0; e.set_cyc = 0; e.name = "";
        if (h > 2 || t > 9 || u > 9 || val > 255) begin
            e.pulses = 0; e.err = 1; e.final_pos = pos; e.busy_cyc = 1;
            return e;
        end
        n = 0;
        case (op)
            OP_LOAD:      n = 1;
            OP_STEP_UP:   n = val;
            OP_STEP_DOWN: begin n = val; e.dir = 1; end
            default: begin
                d = (val - pos + 256) % 256;
                if (d <= 128) n = d;
                else begin n = 256 - d; e.dir = 1; end
            end
        endcase
        if (op == OP_LOAD) e.set_cyc = D + H + L;
        if (freeze_k >= 0 && freeze_k < n) begin
            e.pulses = freeze_k + 1; e.err = 1;
            e.final_pos = e.dir ? ((pos - freeze_k) % 256 + 256) % 256 : (pos + freeze_k) % 256;
            e.busy_cyc = 1 + D + e.pulses * P;
        end else begin
            e.pulses = n; e.err = 0;
            if (op == OP_LOAD) e.final_pos = val;
            else e.final_pos = e.dir ? ((pos - n) % 256 + 256) % 256 : (pos + n) % 256;
            e.busy_cyc = (n == 0) ? 1 : 1 + D + n * P;
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    assign CntOut = to_bcd(cnt);

    // Behavioural counter: on each Step rise either load In (Set) or move one place with wrap.
    initial forever begin
        @(posedge Step);
        if (freeze_at < 0 || total_pulses < freeze_at) begin
            if (Set) cnt = from_bcd(In);
            else if (Reverse) cnt = (cnt + 255) % 256;
            else cnt = (cnt + 1) % 256;
        end
        total_pulses++;
    end

    // Monitor: accumulates activity per command and scores it when done pulses.
    initial begin : monitor
        int pulses_seen, busy_seen, set_seen, hi_seen, in_bad, rev_bad;
        logic step_prev, rev_prev;
        exp_t e;
        pulses_seen = 0; busy_seen = 0; set_seen = 0; hi_seen = 0; in_bad = 0; rev_bad = 0;
        step_prev = 1'b0; rev_prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                pulses_seen = 0; busy_seen = 0; set_seen = 0; hi_seen = 0; in_bad = 0; rev_bad = 0;
                step_prev = 1'b0; rev_prev = 1'b0;
            end else begin
                if (busy) busy_seen++;
                if (Set) set_seen++;
                if (Step) hi_seen++;
                if (Set && sb_q.size() > 0 && In != sb_q[0].value) in_bad++;
                if (Step && !step_prev) begin
                    pulses_seen++;
                    if (sb_q.size() > 0 && int'(Reverse) != sb_q[0].dir) rev_bad++;
                end
                if (Step && step_prev && Reverse != rev_prev) rev_bad++;
                step_prev = Step;
                rev_prev = Reverse;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("%s_err", e.name), int'(err), e.err);
                        check($sformatf("%s_pulses", e.name), pulses_seen, e.pulses);
                        check($sformatf("%s_final", e.name), from_bcd(CntOut), e.final_pos);
                        check($sformatf("%s_busy_cycles", e.name), busy_seen, e.busy_cyc);
                        check($sformatf("%s_set_cycles", e.name), set_seen, e.set_cyc);
                        check($sformatf("%s_step_hi_cycles", e.name), hi_seen, e.pulses * H);
                        check($sformatf("%s_in_value", e.name), in_bad, 0);
                        check($sformatf("%s_reverse", e.name), rev_bad, 0);
                        check($sformatf("%s_done_rev_busy", e.name), int'(Reverse) + int'(busy), 0);
                    end
                    pulses_seen = 0; busy_seen = 0; set_seen = 0; hi_seen = 0; in_bad = 0; rev_bad = 0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [9:0] v, input int freeze_k, input string name);
        exp_t e;
        int guard;
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 100) begin @(negedge Clk); guard++; end
        if (!cmd_if.cmd_ready) begin check($sformatf("%s_ready_timeout", name), 0, 1); return; end
        e = model(op, v, cnt, freeze_k);
        e.name = name;
        freeze_at = (freeze_k >= 0) ? total_pulses + freeze_k : -1;
        sb_q.push_back(e);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op; cmd_if.cmd_value = v;
        @(posedge Clk);
        @(negedge Clk);
        check($sformatf("%s_err_cleared", name), int'(err), 0);
        check($sformatf("%s_busy_after_accept", name), int'(busy), 1);
        guard = 0;
        while (sb_q.size() > 0 && guard < 5000) begin
            // Noise on the command bus while busy must be ignored.
            if (busy) begin
                cmd_if.cmd_valid = 1'($urandom_range(0, 1));
                cmd_if.cmd_op    = 2'($urandom);
                cmd_if.cmd_value = 10'($urandom);
            end else begin
                cmd_if.cmd_valid = 1'b0;
            end
            @(negedge Clk);
            guard++;
        end
        cmd_if.cmd_valid = 1'b0;
        if (guard >= 5000) begin
            check($sformatf("%s_done_timeout", name), 0, 1);
            sb_q.delete();
        end
    endtask

    initial begin
        int guard, val;
        logic [1:0] op;
        logic [9:0] v;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'b00; cmd_if.cmd_value = 10'd0;
        repeat (3) @(negedge Clk);
        check("reset_ready", int'(cmd_if.cmd_ready), 1);
        check("reset_outputs", int'(Step) + int'(Reverse) + int'(Set) + int'(busy) + int'(done) + int'(err), 0);
        check("reset_in", int'(In), 0);
        Rst_n = 1'b1;
        @(negedge Clk);

        issue(OP_LOAD, 10'h123, -1, "load_123");
        issue(OP_LOAD, 10'h254, -1, "load_254");
        issue(OP_STEP_UP, 10'h003, -1, "up3_wrap");
        issue(OP_LOAD, 10'h002, -1, "load_2");
        issue(OP_SEEK, 10'h250, -1, "seek_250_down");
        issue(OP_LOAD, 10'h000, -1, "load_0");
        issue(OP_SEEK, 10'h128, -1, "seek_128_tie");
        issue(OP_LOAD, 10'h000, -1, "load_0b");
        issue(OP_SEEK, 10'h000, -1, "seek_same");
        issue(OP_STEP_DOWN, 10'h000, -1, "down_zero");
        issue(OP_LOAD, 10'h2A0, -1, "load_bad_digit");
        issue(OP_LOAD, 10'h256, -1, "load_256");
        issue(OP_STEP_DOWN, 10'h001, -1, "down1_wrap");
        issue(OP_STEP_UP, 10'h005, 2, "up5_frozen");

        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_STEP_UP || op == OP_STEP_DOWN) val = $urandom_range(0, 12);
            else val = $urandom_range(0, 255);
            v = to_bcd(val);
            if ($urandom_range(0, 7) == 0) v = 10'($urandom);
            issue(op, v, -1, $sformatf("rand%0d", i));
        end

        // LOAD interrupted by reset while Step is high.
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 100) begin @(negedge Clk); guard++; end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_LOAD; cmd_if.cmd_value = 10'h077;
        @(posedge Clk);
        @(negedge Clk);
        cmd_if.cmd_valid = 1'b0;
        guard = 0;
        while (!Step && guard < 50) begin @(negedge Clk); guard++; end
        if (!Step) check("rst_wait_step_timeout", 0, 1);
        Rst_n = 1'b0;
        #1;
        check("rst_step_drop", int'(Step), 0);
        check("rst_set_drop", int'(Set), 0);
        check("rst_busy_drop", int'(busy), 0);
        check("rst_ready", int'(cmd_if.cmd_ready), 1);
        repeat (2) @(negedge Clk);
        sb_q.delete();
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_ready_after_release", int'(cmd_if.cmd_ready), 1);
        check("rst_busy_after_release", int'(busy), 0);
        issue(OP_STEP_DOWN, 10'h003, -1, "down3_after_reset");
        issue(OP_SEEK, 10'h200, -1, "seek_200");

        repeat (3) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
